// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: greedily pays out a requested amount one coin at a
// time from four per-denomination stocks (10/20/50/100), with a hopper ack timeout.
module change_dispenser_ctrl #(
  parameter int DEPTH   = 15,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  input  logic       refill,
  output logic       eject_valid,
  output logic [1:0] eject_coin,
  input  logic       eject_ack,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [3:0] empty,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt [4];
  logic [7:0]      r_remaining;
  logic [1:0]      r_coin;
  logic [TW-1:0]   r_tmo;
  logic            r_fault;
  logic            w_sel_valid;
  logic [1:0]      w_sel_coin;
  logic            w_tmo_hit;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      2'd0:    return 8'd10;
      2'd1:    return 8'd20;
      2'd2:    return 8'd50;
      default: return 8'd100;
    endcase
  endfunction

  // Handshakes: a request is taken on req_valid && req_ready at a rising edge; a
  // coin is taken on eject_valid && eject_ack at a rising edge (same-cycle ack ok).

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_coin  = 2'd0;
    if (r_remaining >= 8'd100 && r_cnt[3] != 4'd0) begin
      w_sel_valid = 1'b1;
      w_sel_coin  = 2'd3;
    end else if (r_remaining >= 8'd50 && r_cnt[2] != 4'd0) begin
      w_sel_valid = 1'b1;
      w_sel_coin  = 2'd2;
    end else if (r_remaining >= 8'd20 && r_cnt[1] != 4'd0) begin
      w_sel_valid = 1'b1;
      w_sel_coin  = 2'd1;
    end else if (r_remaining >= 8'd10 && r_cnt[0] != 4'd0) begin
      w_sel_valid = 1'b1;
      w_sel_coin  = 2'd0;
    end
  end

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid && !refill) w_next = SELECT;
      SELECT:  w_next = w_sel_valid ? EJECT : DONE;
      EJECT:   if (eject_ack) w_next = SELECT;
               else if (w_tmo_hit) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == IDLE) && !refill;
    eject_valid = (r_state == EJECT);
    eject_coin  = (r_state == EJECT) ? r_coin : 2'd0;
    done        = (r_state == DONE);
    shortfall   = (r_state == DONE) ? r_remaining : 8'd0;
    fault       = (r_state == DONE) && r_fault;
    busy        = (r_state != IDLE);
    o_dbg_state = r_state;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) empty[i] = (r_cnt[i] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 4'(DEPTH);
      r_remaining <= 8'd0;
      r_coin      <= 2'd0;
      r_tmo       <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_fault <= 1'b0;
          if (refill) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= 4'(DEPTH);
          end else if (req_valid) begin
            r_remaining <= req_amount;
          end
        end
        SELECT: begin
          r_tmo <= '0;
          if (w_sel_valid) r_coin <= w_sel_coin;
        end
        EJECT: begin
          // A timed-out coin is treated as never delivered: stock and amount stay put.
          if (eject_ack) begin
            r_remaining   <= r_remaining - coin_value(r_coin);
            r_cnt[r_coin] <= r_cnt[r_coin] - 4'd1;
          end else if (w_tmo_hit) begin
            r_fault <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed bench for change_dispenser_ctrl with one coin per denomination, so
// stock depletion is visible on the empty flags.
module tb_change_dispenser_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       refill;
  logic       eject_valid;
  logic [1:0] eject_coin;
  logic       eject_ack;
  logic       done;
  logic [7:0] shortfall;
  logic       fault;
  logic [3:0] empty;
  logic       busy;
  logic [1:0] dbg_state;

  int         n_checks;
  int         n_fail;
  logic [1:0] coins_q[$];
  int         hold_q[$];
  logic [1:0] exp_q[$];
  int         ev_cycles;
  int         first_ev;
  int         got_cyc;
  logic [7:0] got_short;
  logic       got_fault;

  change_dispenser_ctrl #(.DEPTH(1), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .refill     (refill),
    .eject_valid(eject_valid),
    .eject_coin (eject_coin),
    .eject_ack  (eject_ack),
    .done       (done),
    .shortfall  (shortfall),
    .fault      (fault),
    .empty      (empty),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_refill();
    @(negedge clk);
    refill = 1'b1;
    #1 check("refill_blocks_ready", req_ready, 0);
    @(negedge clk);
    refill = 1'b0;
  endtask

  // Issue one request and follow it to done; ack_delay < 0 never acknowledges.
  task automatic run_req(input logic [7:0] amt, input int ack_delay);
    int cyc;
    int wait_n;
    logic fin;
    logic [1:0] held;
    coins_q.delete();
    hold_q.delete();
    ev_cycles = 0; first_ev = 0; got_cyc = 0; got_short = '0; got_fault = 1'b0;
    held = 2'd0;
    @(negedge clk);
    check("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_amount = amt;
    @(negedge clk);
    req_valid = 1'b0;
    req_amount = 8'd0;
    cyc = 1; fin = 1'b0; wait_n = 0;
    while (!fin && cyc < 100) begin
      if (done) begin
        fin = 1'b1;
        got_cyc = cyc;
        got_short = shortfall;
        got_fault = fault;
      end else if (eject_valid) begin
        ev_cycles++;
        if (first_ev == 0) first_ev = cyc;
        if (wait_n == 0) held = eject_coin;
        else check("coin_stable", eject_coin, held);
        if (ack_delay >= 0 && wait_n == ack_delay) begin
          eject_ack = 1'b1;
          coins_q.push_back(held);
          hold_q.push_back(wait_n + 1);
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
      if (!fin) begin
        @(negedge clk);
        eject_ack = 1'b0;
        cyc++;
      end
    end
    if (!fin) check("done_within_budget", 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("shortfall_zero_idle", shortfall, 0);
    check("fault_zero_idle", fault, 0);
    check("busy_after_done", busy, 0);
  endtask

  // scoreboard: compare ejected coins against exp_q
  task automatic check_coins();
    check("coin_count", coins_q.size(), exp_q.size());
    while (exp_q.size() > 0 && coins_q.size() > 0)
      check("coin_code", coins_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
  endtask

  initial begin
    int done_seen;
    n_checks = 0; n_fail = 0;
    req_valid = 1'b0; req_amount = 8'd0; refill = 1'b0; eject_ack = 1'b0;
    do_reset();

    // post-reset outputs
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_eject_valid", eject_valid, 0);
    check("rst_eject_coin", eject_coin, 0);
    check("rst_done", done, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 0);
    check("rst_state", dbg_state, 0);

    // 80 with same-cycle ack: 50,20,10 and done 8 cycles after acceptance
    run_req(8'd80, 0);
    exp_q = '{2'd2, 2'd1, 2'd0};
    check_coins();
    check("r80_first_eject", first_ev, 2);
    check("r80_cycles", got_cyc, 8);
    check("r80_shortfall", got_short, 0);
    check("r80_fault", got_fault, 0);
    check("r80_empty", empty, 4'b0111);
    pulse_refill();
    check("refill_empty", empty, 0);

    // 35: 20,10, shortfall 5
    run_req(8'd35, 0);
    exp_q = '{2'd1, 2'd0};
    check_coins();
    check("r35_shortfall", got_short, 5);
    pulse_refill();

    // two requests of 30 with a single coin per stock
    run_req(8'd30, 0);
    exp_q = '{2'd1, 2'd0};
    check_coins();
    check("r30a_shortfall", got_short, 0);
    check("r30a_empty", empty, 4'b0011);
    run_req(8'd30, 0);
    check_coins();
    check("r30b_shortfall", got_short, 30);
    check("r30b_cycles", got_cyc, 2);
    pulse_refill();
    check("r30_refill_empty", empty, 0);

    // zero amount
    run_req(8'd0, 0);
    check_coins();
    check("r0_shortfall", got_short, 0);
    check("r0_cycles", got_cyc, 2);

    // ack delayed 3 cycles: coin held 4 cycles, one decrement
    run_req(8'd20, 3);
    exp_q = '{2'd1};
    check_coins();
    check("dly_hold", (hold_q.size() > 0) ? hold_q[0] : 0, 4);
    check("dly_ev_cycles", ev_cycles, 4);
    check("dly_empty", empty, 4'b0010);
    check("dly_cycles", got_cyc, 7);
    pulse_refill();

    // no ack: timeout after 8 eject cycles
    run_req(8'd60, -1);
    check("tmo_ev_cycles", ev_cycles, 8);
    check("tmo_fault", got_fault, 1);
    check("tmo_shortfall", got_short, 60);
    check("tmo_cycles", got_cyc, 10);
    check("tmo_empty", empty, 0);

    // 200 drains every stock, greedy leaves 20 unpaid
    run_req(8'd200, 0);
    exp_q = '{2'd3, 2'd2, 2'd1, 2'd0};
    check_coins();
    check("r200_shortfall", got_short, 20);
    check("r200_empty", empty, 4'b1111);
    pulse_refill();

    // reset while in EJECT
    run_req(8'd10, 0);
    check("pre_rst_empty", empty, 4'b0001);
    @(negedge clk);
    req_valid = 1'b1; req_amount = 8'd50;
    @(negedge clk);
    req_valid = 1'b0; req_amount = 8'd0;
    @(negedge clk);
    check("mid_eject_valid", eject_valid, 1);
    check("mid_eject_coin", eject_coin, 2);
    check("mid_state", dbg_state, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstx_eject_valid", eject_valid, 0);
    check("rstx_done", done, 0);
    check("rstx_req_ready", req_ready, 1);
    check("rstx_empty", empty, 0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || eject_valid) done_seen++;
    end
    check("rstx_no_activity", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
